// File: rtl/fx_kport_pad_if.sv
// PC-FX K-port serial bus: the host drives latch/clock/direction/data,
// and the pad answers on KP_DIN. All data lines are active-low.
interface fx_kport_pad_if;
    logic KP_LATCH;
    logic KP_CLK;
    logic KP_RW;
    logic KP_DOUT;
    logic KP_DIN;

    modport master (output KP_LATCH, output KP_CLK, output KP_RW, output KP_DOUT, input KP_DIN);
    modport slave  (input KP_LATCH, input KP_CLK, input KP_RW, input KP_DOUT, output KP_DIN);
endinterface

// File: rtl/fx_kport_pad.sv
// Joypad end of the PC-FX K-port: shifts out {PAD_ID, 12'h000, BTN} on read
// frames and captures 32 host bits on write frames.
module fx_kport_pad #(
    parameter logic [3:0] PAD_ID      = 4'hF,
    parameter int         SYNC_STAGES = 2
) (
    input  logic               CLK,
    input  logic               RES,
    input  logic               CE,
    input  logic [15:0]        BTN,
    fx_kport_pad_if.slave      kp,
    output logic [31:0]        RX_DATA,
    output logic               RX_VALID,
    output logic               BUSY
);

    localparam int STAGES = (SYNC_STAGES < 1) ? 1 : SYNC_STAGES;

    typedef enum logic [1:0] {IDLE, TX, RX} state_t;

    // Each synchronizer stage carries {latch, clk, rw, dout}; all preset high.
    logic [3:0] sync_q [STAGES];
    logic [3:0] prev_q;
    logic [3:0] cur;

    logic latch_f;
    logic clk_r;
    logic clk_f;

    state_t      state, state_n;
    logic [31:0] sr, sr_n;
    logic [5:0]  cnt, cnt_n;
    logic        din_q, din_n;
    logic [31:0] rx_data_n;
    logic        rx_valid_n;
    logic        busy_n;

    assign cur     = sync_q[STAGES-1];
    assign latch_f = prev_q[3] & ~cur[3];
    assign clk_r   = ~prev_q[2] & cur[2];
    assign clk_f   = prev_q[2] & ~cur[2];

    always_ff @(posedge CLK) begin
        if (RES) begin
            for (int i = 0; i < STAGES; i++) sync_q[i] <= 4'hF;
            prev_q <= 4'hF;
        end else if (CE) begin
            sync_q[0] <= {kp.KP_LATCH, kp.KP_CLK, kp.KP_RW, kp.KP_DOUT};
            for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= cur;
        end
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            state    <= IDLE;
            sr       <= 32'h0;
            cnt      <= 6'd0;
            din_q    <= 1'b1;
            RX_DATA  <= 32'h0;
            RX_VALID <= 1'b0;
            BUSY     <= 1'b0;
        end else if (CE) begin
            state    <= state_n;
            sr       <= sr_n;
            cnt      <= cnt_n;
            din_q    <= din_n;
            RX_DATA  <= rx_data_n;
            RX_VALID <= rx_valid_n;
            BUSY     <= busy_n;
        end
    end

    // A latch fall always restarts the frame; clock edges only count while latch is high.
    always_comb begin
        state_n    = state;
        sr_n       = sr;
        cnt_n      = cnt;
        rx_data_n  = RX_DATA;
        rx_valid_n = 1'b0;

        if (latch_f) begin
            cnt_n = 6'd0;
            if (cur[1]) begin
                sr_n    = {PAD_ID, 12'h000, BTN};
                state_n = TX;
            end else begin
                sr_n    = 32'h0;
                state_n = RX;
            end
        end else if (cur[3]) begin
            case (state)
                TX: begin
                    if (clk_r) begin
                        sr_n  = {1'b0, sr[31:1]};
                        cnt_n = cnt + 6'd1;
                        if (cnt_n == 6'd32) state_n = IDLE;
                    end
                end
                RX: begin
                    if (clk_f) begin
                        sr_n  = {~cur[0], sr[31:1]};
                        cnt_n = cnt + 6'd1;
                        if (cnt_n == 6'd32) begin
                            rx_data_n  = sr_n;
                            rx_valid_n = 1'b1;
                            state_n    = IDLE;
                        end
                    end
                end
                default: ;
            endcase
        end

        din_n  = (state_n == TX) ? ~sr_n[0] : 1'b1;
        busy_n = (state_n != IDLE);
    end

    assign kp.KP_DIN = din_q;

endmodule

// File: tb/tb_fx_kport_pad.sv
// Bench for fx_kport_pad: a frame-level host plus a reference model of the
// pad that is compared against the DUT every clock.
module tb_fx_kport_pad;

    localparam int SYNC = 2;
    localparam logic [3:0] PAD = 4'hF;

    logic        CLK = 1'b0;
    logic        RES;
    logic        CE;
    logic [15:0] BTN;
    logic [31:0] RX_DATA;
    logic        RX_VALID;
    logic        BUSY;

    fx_kport_pad_if kp ();

    fx_kport_pad #(.PAD_ID(PAD), .SYNC_STAGES(SYNC)) dut (
        .CLK      (CLK),
        .RES      (RES),
        .CE       (CE),
        .BTN      (BTN),
        .kp       (kp),
        .RX_DATA  (RX_DATA),
        .RX_VALID (RX_VALID),
        .BUSY     (BUSY)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int fails  = 0;
    int hp     = 4;
    int ce_mode = 0;
    int valid_cycles = 0;
    int valid_pulses = 0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // CE pattern: always on, one-in-four, or held off.
    initial begin
        int cnt;
        cnt = 0;
        CE = 1'b1;
        forever begin
            @(negedge CLK);
            if (ce_mode == 0) CE = 1'b1;
            else if (ce_mode == 1) CE = (cnt % 4 == 0);
            else CE = 1'b0;
            cnt++;
        end
    end

    // Reference pad: pins become visible SYNC+1 enabled cycles later, then the
    // frame rules act on bit indices rather than a shift register.
    int          m_mode;
    int          m_nbits;
    logic [31:0] m_frame, m_word, m_rx_data;
    logic        m_rx_valid, m_din, m_busy;
    logic [3:0]  hist [SYNC+1];
    logic [3:0]  cur_p, old_p;
    bit          model_ready = 0;

    initial begin
        forever begin
            @(posedge CLK);
            if (RES === 1'b1) begin
                for (int i = 0; i <= SYNC; i++) hist[i] = 4'hF;
                m_mode = 0; m_nbits = 0; m_frame = 0; m_word = 0;
                m_rx_data = 0; m_rx_valid = 0; m_din = 1; m_busy = 0;
                model_ready = 1;
            end else if (CE === 1'b1 && model_ready) begin
                cur_p = hist[SYNC-1];
                old_p = hist[SYNC];
                m_rx_valid = 0;
                if (old_p[3] && !cur_p[3]) begin
                    m_nbits = 0;
                    if (cur_p[1]) begin
                        m_mode = 1;
                        m_frame = {PAD, 12'h000, BTN};
                    end else begin
                        m_mode = 2;
                        m_word = 0;
                    end
                end else if (cur_p[3]) begin
                    if (m_mode == 1 && !old_p[2] && cur_p[2]) begin
                        m_nbits++;
                        if (m_nbits == 32) m_mode = 0;
                    end else if (m_mode == 2 && old_p[2] && !cur_p[2]) begin
                        m_word[m_nbits] = ~cur_p[0];
                        m_nbits++;
                        if (m_nbits == 32) begin
                            m_rx_data = m_word;
                            m_rx_valid = 1;
                            m_mode = 0;
                        end
                    end
                end
                m_din  = (m_mode == 1) ? ~m_frame[m_nbits] : 1'b1;
                m_busy = (m_mode != 0);
                for (int i = SYNC; i > 0; i--) hist[i] = hist[i-1];
                hist[0] = {kp.KP_LATCH, kp.KP_CLK, kp.KP_RW, kp.KP_DOUT};
            end
        end
    end

    initial begin
        forever begin
            @(negedge CLK);
            if (model_ready) begin
                check_output("din", {31'b0, kp.KP_DIN}, {31'b0, m_din});
                check_output("busy", {31'b0, BUSY}, {31'b0, m_busy});
                check_output("rx_data", RX_DATA, m_rx_data);
                check_output("rx_valid", {31'b0, RX_VALID}, {31'b0, m_rx_valid});
            end
        end
    end

    initial begin
        logic prev_v;
        prev_v = 1'b0;
        forever begin
            @(negedge CLK);
            if (RX_VALID === 1'b1) begin
                valid_cycles++;
                if (!prev_v) valid_pulses++;
            end
            prev_v = (RX_VALID === 1'b1);
        end
    end

    task automatic host_latch(input logic rw);
        kp.KP_RW = rw;
        wait_cycles(hp);
        kp.KP_LATCH = 1'b0;
        wait_cycles(2*hp);
        kp.KP_LATCH = 1'b1;
        wait_cycles(2*hp);
    endtask

    // Host samples each bit just before raising its clock.
    task automatic host_read(input int n, output logic [31:0] word);
        word = 32'h0;
        for (int i = 0; i < n; i++) begin
            kp.KP_CLK = 1'b0;
            wait_cycles(hp);
            word[i] = ~kp.KP_DIN;
            kp.KP_CLK = 1'b1;
            wait_cycles(hp);
        end
    endtask

    task automatic host_write(input int n, input logic [31:0] word);
        for (int i = 0; i < n; i++) begin
            kp.KP_DOUT = ~word[i];
            wait_cycles(hp);
            kp.KP_CLK = 1'b0;
            wait_cycles(hp);
            kp.KP_CLK = 1'b1;
        end
        wait_cycles(hp);
        kp.KP_DOUT = 1'b1;
    endtask

    initial begin
        logic [31:0] w, w1, w2;
        int p0, v0;
        bit frozen_bad;
        logic [34:0] snap;

        RES = 1'b1;
        BTN = 16'h0000;
        kp.KP_LATCH = 1'b1;
        kp.KP_CLK = 1'b1;
        kp.KP_RW = 1'b1;
        kp.KP_DOUT = 1'b1;
        wait_cycles(3);
        RES = 1'b0;
        wait_cycles(2);
        check_output("reset_din", {31'b0, kp.KP_DIN}, 32'd1);
        check_output("reset_busy", {31'b0, BUSY}, 32'd0);
        check_output("reset_rx_data", RX_DATA, 32'h0);
        check_output("reset_rx_valid", {31'b0, RX_VALID}, 32'd0);

        $display("[TB] read frame");
        BTN = 16'h0005;
        host_latch(1'b1);
        check_output("read_busy_on", {31'b0, BUSY}, 32'd1);
        host_read(32, w);
        check_output("read_word", w, 32'hF000_0005);
        wait_cycles(2*hp);
        check_output("read_busy_off", {31'b0, BUSY}, 32'd0);
        check_output("read_din_idle", {31'b0, kp.KP_DIN}, 32'd1);

        $display("[TB] write frame");
        v0 = valid_cycles;
        host_latch(1'b0);
        host_write(32, 32'hA5A5_1234);
        wait_cycles(2*hp);
        check_output("write_rx_data", RX_DATA, 32'hA5A5_1234);
        check_output("write_valid_cycles", valid_cycles - v0, 32'd1);

        $display("[TB] abort mid-frame");
        BTN = 16'h0001;
        host_latch(1'b1);
        host_read(10, w);
        check_output("abort_first_bits", {22'b0, w[9:0]}, 32'h001);
        BTN = 16'h8000;
        host_latch(1'b1);
        host_read(32, w);
        check_output("abort_read_word", w, 32'hF000_8000);
        wait_cycles(2*hp);

        p0 = valid_pulses;
        host_latch(1'b0);
        host_write(20, 32'h0000_FFFF);
        host_latch(1'b0);
        check_output("abort_rx_no_valid", valid_pulses - p0, 32'd0);
        check_output("abort_rx_data_kept", RX_DATA, 32'hA5A5_1234);
        host_write(32, 32'h1357_9BDF);
        wait_cycles(2*hp);
        check_output("abort_rx_new_frame", RX_DATA, 32'h1357_9BDF);
        check_output("abort_rx_one_valid", valid_pulses - p0, 32'd1);

        $display("[TB] direction lock");
        BTN = 16'h0005;
        host_latch(1'b1);
        kp.KP_RW = 1'b0;
        host_read(32, w);
        wait_cycles(2*hp);
        check_output("lock_read_word", w, 32'hF000_0005);
        check_output("lock_rx_data", RX_DATA, 32'h1357_9BDF);
        kp.KP_RW = 1'b1;

        $display("[TB] CE one-in-four");
        ce_mode = 1;
        hp = 8;
        host_latch(1'b1);
        host_read(32, w);
        wait_cycles(2*hp);
        check_output("ce_read_word", w, 32'hF000_0005);
        check_output("ce_busy_off", {31'b0, BUSY}, 32'd0);
        p0 = valid_pulses;
        host_latch(1'b0);
        host_write(32, 32'hA5A5_1234);
        wait_cycles(2*hp);
        check_output("ce_rx_data", RX_DATA, 32'hA5A5_1234);
        check_output("ce_rx_pulses", valid_pulses - p0, 32'd1);

        $display("[TB] CE freeze");
        ce_mode = 0;
        hp = 4;
        wait_cycles(2);
        host_latch(1'b1);
        host_read(5, w1);
        ce_mode = 2;
        wait_cycles(2);
        snap = {kp.KP_DIN, BUSY, RX_VALID, RX_DATA};
        frozen_bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (i % 10 == 0) kp.KP_CLK = ~kp.KP_CLK;
            @(negedge CLK);
            if ({kp.KP_DIN, BUSY, RX_VALID, RX_DATA} !== snap) frozen_bad = 1;
        end
        kp.KP_CLK = 1'b1;
        check_output("freeze_outputs_held", {31'b0, frozen_bad}, 32'd0);
        ce_mode = 0;
        wait_cycles(2);
        host_read(27, w2);
        check_output("freeze_resumed_word", {w2[26:0], w1[4:0]}, 32'hF000_0005);
        wait_cycles(2*hp);

        $display("[TB] reset mid-TX");
        host_latch(1'b1);
        host_read(10, w);
        RES = 1'b1;
        @(negedge CLK);
        check_output("res_din", {31'b0, kp.KP_DIN}, 32'd1);
        check_output("res_busy", {31'b0, BUSY}, 32'd0);
        check_output("res_rx_data", RX_DATA, 32'h0);
        check_output("res_rx_valid", {31'b0, RX_VALID}, 32'd0);
        RES = 1'b0;
        wait_cycles(2);
        host_read(8, w);
        check_output("res_no_shift_word", w, 32'h0);
        check_output("res_no_shift_busy", {31'b0, BUSY}, 32'd0);
        wait_cycles(4);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
